// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use, branch, jump, imem wait, mult/div.
// Optional perf counters behind HAZARD_PERF_CNT_EN.
module hazard_stall_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rt,
  input  logic        branch_taken_ex,
  input  logic        jump_id,
  input  logic        md_start,
  input  logic        md_is_div,
  input  logic        imem_ready,
  output logic        pc_hold,
  output logic        hold_IFID,
  output logic        flush_IFID,
  output logic        hold_IDEX,
  output logic        flush_IDEX,
  output logic        md_busy,
  output logic        md_done,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
);

  typedef enum logic {RUN, MD_WAIT} state_t;

  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 2);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 2);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             load_use;
  logic [6:0]       outs;

  assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) || (ex_rt == id_rt));

  // outs = {pc_hold, hold_IFID, flush_IFID, hold_IDEX, flush_IDEX, md_busy, md_done}
  always_comb begin
    outs      = 7'b0;
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      RUN: begin
        if (branch_taken_ex) begin
          outs = 7'b0010100;
        end else if (md_start) begin
          outs      = 7'b1101000;
          cnt_nxt   = md_is_div ? DIV_CNT : MUL_CNT;
          state_nxt = MD_WAIT;
        end else if (load_use) begin
          outs = 7'b1100100;
        end else if (jump_id) begin
          outs = 7'b0010000;
        end else if (!imem_ready) begin
          outs = 7'b1010000;
        end
      end
      MD_WAIT: begin
        if (cnt != '0) begin
          outs    = 7'b1101010;
          cnt_nxt = cnt - 1'b1;
        end else begin
          outs      = 7'b1101011;
          state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign {pc_hold, hold_IFID, flush_IFID, hold_IDEX,
          flush_IDEX, md_busy, md_done} = reset ? 7'b0 : outs;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_q, flush_q;

  // Saturating: the max value sticks until reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (pc_hold && (stall_q != 32'hFFFF_FFFF))
        stall_q <= stall_q + 32'd1;
      if ((flush_IFID || flush_IDEX) && (flush_q != 32'hFFFF_FFFF))
        flush_q <= flush_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`else
  assign stall_cycles = 32'd0;
  assign flush_count  = 32'd0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(hold_IFID && flush_IFID));
      assert (!(hold_IDEX && flush_IDEX));
      assert (!(md_done && (state != MD_WAIT)));
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl.
// Output vector order: {pc_hold, hold_IFID, flush_IFID, hold_IDEX, flush_IDEX, md_busy, md_done}.
module tb_hazard_stall_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        ex_mem_read, branch_taken_ex, jump_id;
  logic        md_start, md_is_div, imem_ready;
  logic        pc_hold, hold_IFID, flush_IFID, hold_IDEX, flush_IDEX;
  logic        md_busy, md_done;
  logic [31:0] stall_cycles, flush_count;
  logic [6:0]  outs;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .ex_mem_read     (ex_mem_read),
    .ex_rt           (ex_rt),
    .branch_taken_ex (branch_taken_ex),
    .jump_id         (jump_id),
    .md_start        (md_start),
    .md_is_div       (md_is_div),
    .imem_ready      (imem_ready),
    .pc_hold         (pc_hold),
    .hold_IFID       (hold_IFID),
    .flush_IFID      (flush_IFID),
    .hold_IDEX       (hold_IDEX),
    .flush_IDEX      (flush_IDEX),
    .md_busy         (md_busy),
    .md_done         (md_done),
    .stall_cycles    (stall_cycles),
    .flush_count     (flush_count)
  );

  assign outs = {pc_hold, hold_IFID, flush_IFID, hold_IDEX,
                 flush_IDEX, md_busy, md_done};

  localparam logic [6:0] NONE = 7'b0000000;
  localparam logic [6:0] LDU  = 7'b1100100;
  localparam logic [6:0] BR   = 7'b0010100;
  localparam logic [6:0] JMP  = 7'b0010000;
  localparam logic [6:0] IMW  = 7'b1010000;
  localparam logic [6:0] MDS  = 7'b1101000;
  localparam logic [6:0] MDW  = 7'b1101010;
  localparam logic [6:0] MDD  = 7'b1101011;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle;
    id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
    ex_mem_read = 1'b0; branch_taken_ex = 1'b0; jump_id = 1'b0;
    md_start = 1'b0; md_is_div = 1'b0; imem_ready = 1'b1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    tick;
    reset = 1'b1;
    idle;
    #2;
    reset = 1'b0;
  endtask

  task automatic hazards_on;
    ex_mem_read = 1'b1; ex_rt = 5'd9; id_rs = 5'd9;
    branch_taken_ex = 1'b1; jump_id = 1'b1; imem_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle;
    hazards_on;
    md_start = 1'b1;
    #3;
    check("rst_outs", 32'(outs), 32'(NONE));
    check("rst_stall", stall_cycles, 32'd0);
    check("rst_flush", flush_count, 32'd0);
    #4;
    reset = 1'b0;
    idle;

    tick; idle; #1;
    check("idle", 32'(outs), 32'(NONE));

    tick; idle; ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; #1;
    check("ldu_rs", 32'(outs), 32'(LDU));
    tick; idle; #1;
    check("ldu_one_bubble", 32'(outs), 32'(NONE));

    tick; idle; ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; #1;
    check("ldu_r0", 32'(outs), 32'(NONE));

    tick; idle; ex_mem_read = 1'b1; ex_rt = 5'd5; id_rt = 5'd5; id_rs = 5'd3; #1;
    check("ldu_rt", 32'(outs), 32'(LDU));

    tick; idle; ex_mem_read = 1'b0; ex_rt = 5'd5; id_rt = 5'd5; #1;
    check("no_load", 32'(outs), 32'(NONE));

    tick; idle; branch_taken_ex = 1'b1;
    ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; #1;
    check("br_over_ldu", 32'(outs), 32'(BR));

    tick; idle; branch_taken_ex = 1'b1; md_start = 1'b1; #1;
    check("br_over_md", 32'(outs), 32'(BR));
    tick; idle; #1;
    check("md_ignored", 32'(outs), 32'(NONE));

    tick; idle; jump_id = 1'b1;
    ex_mem_read = 1'b1; ex_rt = 5'd4; id_rt = 5'd4; #1;
    check("ldu_over_jmp", 32'(outs), 32'(LDU));

    tick; idle; md_start = 1'b1; ex_mem_read = 1'b1; ex_rt = 5'd4; id_rt = 5'd4; #1;
    check("md_over_ldu", 32'(outs), 32'(MDS));
    do_reset;

    tick; idle; jump_id = 1'b1; imem_ready = 1'b0; #1;
    check("imw_c1_jmp", 32'(outs), 32'(JMP));
    tick; idle; imem_ready = 1'b0; #1;
    check("imw_c2", 32'(outs), 32'(IMW));
    tick; idle; imem_ready = 1'b0; #1;
    check("imw_c3", 32'(outs), 32'(IMW));
    tick; idle; #1;
    check("imw_done", 32'(outs), 32'(NONE));

    // Multiply: 4-cycle stall, then one taken branch for the perf counters
    do_reset;
    tick; idle; md_start = 1'b1; #1;
    check("mul_c1", 32'(outs), 32'(MDS));
    for (int i = 2; i <= 4; i++) begin
      tick; idle; hazards_on; #1;
      check($sformatf("mul_c%0d", i), 32'(outs), 32'(i == 4 ? MDD : MDW));
    end
    tick; idle; #1;
    check("mul_c5_run", 32'(outs), 32'(NONE));
    tick; idle; branch_taken_ex = 1'b1; #1;
    check("perf_br", 32'(outs), 32'(BR));
    tick; idle; #1;
`ifdef HAZARD_PERF_CNT_EN
    check("perf_stall", stall_cycles, 32'd4);
    check("perf_flush", flush_count, 32'd1);
`else
    check("perf_stall", stall_cycles, 32'd0);
    check("perf_flush", flush_count, 32'd0);
`endif

    // Divide aborted by reset on the 10th stall cycle
    tick; idle; md_start = 1'b1; md_is_div = 1'b1; #1;
    check("div_c1", 32'(outs), 32'(MDS));
    for (int i = 2; i <= 9; i++) begin
      tick; idle; #1;
      check($sformatf("div_c%0d", i), 32'(outs), 32'(MDW));
    end
    tick; idle; hazards_on; reset = 1'b1; #1;
    check("div_rst_outs", 32'(outs), 32'(NONE));
    check("div_rst_busy", 32'(md_busy), 32'd0);
    idle; reset = 1'b0;
    tick; idle; #1;
    check("div_rst_run", 32'(outs), 32'(NONE));

    // Full divide: 32 stall cycles
    tick; idle; md_start = 1'b1; md_is_div = 1'b1; #1;
    check("fdiv_c1", 32'(outs), 32'(MDS));
    for (int i = 2; i <= 32; i++) begin
      tick; idle; #1;
      check($sformatf("fdiv_c%0d", i), 32'(outs), 32'(i == 32 ? MDD : MDW));
    end
    tick; idle; #1;
    check("fdiv_c33_run", 32'(outs), 32'(NONE));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
